// File: rtl/alu_exec_pipe.sv
// Pipelined integer functional unit: issue from reservation station, fixed-latency
// broadcast of result/exception on one CDB slot. No back-pressure, flush squashes all work.
module alu_exec_pipe #(
  parameter int unsigned NUM_STAGES = 3,
  parameter int unsigned ROB_IDX_W  = 4,
  parameter int unsigned DATA_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [ROB_IDX_W-1:0] in_instr_index,
  input  logic [15:0]          in_instr_full,
  input  logic [DATA_W-1:0]    in_val1,
  input  logic [DATA_W-1:0]    in_val2,
  input  logic                 flush,
  output logic                 cdb_valid,
  output logic [ROB_IDX_W-1:0] cdb_rob_index,
  output logic [DATA_W-1:0]    cdb_result,
  output logic                 cdb_exc,
  output logic [3:0]           inflight_cnt
);

  localparam int unsigned OPC_W = 4;
  localparam int unsigned SH_W  = 4;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned RS_N  = NUM_STAGES - 1;

  // Stage 0: captured issue operands
  logic                 s0_v;
  logic [ROB_IDX_W-1:0] s0_idx;
  logic [OPC_W-1:0]     s0_op;
  logic [DATA_W-1:0]    s0_a;
  logic [DATA_W-1:0]    s0_b;

  // Result stages; the last one is the CDB output register
  logic [RS_N-1:0]      r_v;
  logic [ROB_IDX_W-1:0] r_idx [RS_N];
  logic [DATA_W-1:0]    r_res [RS_N];
  logic                 r_exc [RS_N];

  logic                 s0_v_nxt;
  logic [RS_N-1:0]      r_v_nxt;
  logic [CNT_W-1:0]     cnt_nxt;
  logic [DATA_W-1:0]    alu_res_c;
  logic                 alu_exc_c;
  logic                 unused_instr_c;

  assign unused_instr_c = ^in_instr_full[11:0];

  // Opcode decode and execute on stage-0 operands
  always_comb begin : exec
    alu_res_c = '0;
    alu_exc_c = 1'b0;
    case (s0_op)
      4'd0:    alu_res_c = s0_a + s0_b;
      4'd1:    alu_res_c = s0_a - s0_b;
      4'd2:    alu_res_c = s0_a & s0_b;
      4'd3:    alu_res_c = s0_a | s0_b;
      4'd4:    alu_res_c = s0_a ^ s0_b;
      4'd5:    alu_res_c = s0_a << s0_b[SH_W-1:0];
      4'd6:    alu_res_c = s0_a >> s0_b[SH_W-1:0];
      4'd7:    alu_res_c = ($signed(s0_a) < $signed(s0_b)) ? DATA_W'(1) : '0;
      4'd8:    alu_res_c = DATA_W'(s0_a * s0_b);
      default: alu_exc_c = 1'b1;
    endcase
  end

  // Valid chain with flush squash, and registered occupancy count
  always_comb begin : valid_next
    s0_v_nxt   = in_valid & ~flush;
    r_v_nxt    = '0;
    r_v_nxt[0] = s0_v & ~flush;
    for (int unsigned i = 1; i < RS_N; i++) begin
      r_v_nxt[i] = r_v[i-1] & ~flush;
    end
    cnt_nxt = CNT_W'(s0_v_nxt);
    for (int unsigned i = 0; i < RS_N; i++) begin
      cnt_nxt = cnt_nxt + CNT_W'(r_v_nxt[i]);
    end
  end

  // Data moves only behind a valid entry, so the CDB fields hold between broadcasts
  always_ff @(posedge clk) begin
    if (rst) begin
      s0_v         <= 1'b0;
      s0_idx       <= '0;
      s0_op        <= '0;
      s0_a         <= '0;
      s0_b         <= '0;
      r_v          <= '0;
      inflight_cnt <= '0;
      for (int unsigned i = 0; i < RS_N; i++) begin
        r_idx[i] <= '0;
        r_res[i] <= '0;
        r_exc[i] <= 1'b0;
      end
    end else begin
      s0_v         <= s0_v_nxt;
      r_v          <= r_v_nxt;
      inflight_cnt <= cnt_nxt;
      if (in_valid) begin
        s0_idx <= in_instr_index;
        s0_op  <= in_instr_full[15:12];
        s0_a   <= in_val1;
        s0_b   <= in_val2;
      end
      if (s0_v) begin
        r_idx[0] <= s0_idx;
        r_res[0] <= alu_res_c;
        r_exc[0] <= alu_exc_c;
      end
      for (int unsigned i = 1; i < RS_N; i++) begin
        if (r_v[i-1]) begin
          r_idx[i] <= r_idx[i-1];
          r_res[i] <= r_res[i-1];
          r_exc[i] <= r_exc[i-1];
        end
      end
    end
  end

  assign cdb_valid     = r_v[RS_N-1];
  assign cdb_rob_index = r_idx[RS_N-1];
  assign cdb_result    = r_res[RS_N-1];
  assign cdb_exc       = r_exc[RS_N-1];

endmodule

// File: tb/tb_alu_exec_pipe.sv
// Directed and random bench for alu_exec_pipe: scoreboard of expected broadcasts keyed
// by due cycle, checked together with the occupancy count every cycle.
module tb_alu_exec_pipe;

  localparam int unsigned LAT = 3;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [3:0]  in_instr_index;
  logic [15:0] in_instr_full;
  logic [15:0] in_val1;
  logic [15:0] in_val2;
  logic        flush;
  logic        cdb_valid;
  logic [3:0]  cdb_rob_index;
  logic [15:0] cdb_result;
  logic        cdb_exc;
  logic [3:0]  inflight_cnt;

  alu_exec_pipe #(.NUM_STAGES(LAT), .ROB_IDX_W(4), .DATA_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_instr_index(in_instr_index),
    .in_instr_full(in_instr_full), .in_val1(in_val1), .in_val2(in_val2), .flush(flush),
    .cdb_valid(cdb_valid), .cdb_rob_index(cdb_rob_index), .cdb_result(cdb_result),
    .cdb_exc(cdb_exc), .inflight_cnt(inflight_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [3:0]  idx;
    logic [15:0] res;
    logic        exc;
  } exp_t;

  exp_t q[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [16:0] ref_alu(input logic [3:0] op, input logic [15:0] a,
                                          input logic [15:0] b);
    logic [31:0] p;
    p = 32'(a) * 32'(b);
    case (op)
      4'd0: return {1'b0, 16'(a + b)};
      4'd1: return {1'b0, 16'(a - b)};
      4'd2: return {1'b0, a & b};
      4'd3: return {1'b0, a | b};
      4'd4: return {1'b0, a ^ b};
      4'd5: return {1'b0, 16'(a << b[3:0])};
      4'd6: return {1'b0, 16'(a >> b[3:0])};
      4'd7: return {1'b0, 15'd0, ($signed(a) < $signed(b))};
      4'd8: return {1'b0, p[15:0]};
      default: return {1'b1, 16'h0000};
    endcase
  endfunction

  // Compare outputs of the current cycle against the scoreboard
  task automatic check_cycle();
    int n = 0;
    foreach (q[i]) if (q[i].due <= cyc + int'(LAT) - 1) n++;
    check("inflight_cnt", 32'(inflight_cnt), 32'(n));
    if (q.size() > 0 && q[0].due == cyc) begin
      check("cdb_valid", 32'(cdb_valid), 32'd1);
      check("cdb_rob_index", 32'(cdb_rob_index), 32'(q[0].idx));
      check("cdb_result", 32'(cdb_result), 32'(q[0].res));
      check("cdb_exc", 32'(cdb_exc), 32'(q[0].exc));
      void'(q.pop_front());
    end else begin
      check("cdb_valid_idle", 32'(cdb_valid), 32'd0);
    end
  endtask

  // One cycle: check, drive, update model, advance past the edge
  task automatic step(input logic v, input logic [3:0] idx, input logic [3:0] op,
                      input logic [15:0] a, input logic [15:0] b, input logic fl,
                      input logic r, input logic [15:0] eres, input logic eexc);
    exp_t e;
    check_cycle();
    in_valid       = v;
    in_instr_index = idx;
    in_instr_full  = {op, 12'h5A3};
    in_val1        = a;
    in_val2        = b;
    flush          = fl;
    rst            = r;
    if (fl || r) begin
      while (q.size() > 0 && q[$].due > cyc) void'(q.pop_back());
    end else if (v) begin
      e.due = cyc + int'(LAT);
      e.idx = idx;
      e.res = eres;
      e.exc = eexc;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 4'd0, 4'd0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0);
  endtask

  task automatic issue(input logic [3:0] idx, input logic [3:0] op, input logic [15:0] a,
                       input logic [15:0] b, input logic [15:0] eres, input logic eexc);
    step(1'b1, idx, op, a, b, 1'b0, 1'b0, eres, eexc);
  endtask

  initial begin
    logic [16:0] rr;
    logic        v, fl, r;
    logic [3:0]  op, idx;
    logic [15:0] a, b;

    // Reset held 2 cycles while issuing
    rst = 1'b1; in_valid = 1'b1; in_instr_index = 4'd1; in_instr_full = 16'h0000;
    in_val1 = 16'h1111; in_val2 = 16'h2222; flush = 1'b0;
    @(posedge clk);
    #1;
    check("rst_cdb_result", 32'(cdb_result), 32'h0);
    check("rst_cdb_rob_index", 32'(cdb_rob_index), 32'h0);
    check("rst_cdb_exc", 32'(cdb_exc), 32'h0);
    step(1'b1, 4'd2, 4'd0, 16'h1, 16'h1, 1'b0, 1'b1, 16'h2, 1'b0);
    idle(2);

    // Single ADD with wraparound
    issue(4'd5, 4'd0, 16'hFFFF, 16'h0002, 16'h0001, 1'b0);
    idle(4);

    // Back-to-back SUB, SHL, SLT, MUL
    issue(4'd1, 4'd1, 16'h0003, 16'h0001, 16'h0002, 1'b0);
    issue(4'd2, 4'd5, 16'h0001, 16'h0004, 16'h0010, 1'b0);
    issue(4'd3, 4'd7, 16'h8000, 16'h0001, 16'h0001, 1'b0);
    issue(4'd4, 4'd8, 16'h0100, 16'h0101, 16'h0100, 1'b0);
    idle(4);

    // Flush with same-cycle issue, then reissue
    issue(4'd6, 4'd0, 16'h0001, 16'h0001, 16'h0002, 1'b0);
    issue(4'd7, 4'd2, 16'h00FF, 16'h0F0F, 16'h000F, 1'b0);
    step(1'b1, 4'd8, 4'd0, 16'h1, 16'h1, 1'b1, 1'b0, 16'h2, 1'b0);
    issue(4'd9, 4'd0, 16'h0002, 16'h0003, 16'h0005, 1'b0);
    idle(4);

    // Illegal opcode followed by ADD
    issue(4'd9, 4'hC, 16'h1234, 16'h5678, 16'h0000, 1'b1);
    issue(4'd10, 4'd0, 16'h0004, 16'h0004, 16'h0008, 1'b0);
    idle(4);

    // Remaining ops and shift-amount boundaries
    issue(4'd11, 4'd3, 16'hA000, 16'h000A, 16'hA00A, 1'b0);
    issue(4'd12, 4'd4, 16'hFF00, 16'h0FF0, 16'hF0F0, 1'b0);
    issue(4'd13, 4'd6, 16'h8000, 16'h000F, 16'h0001, 1'b0);
    issue(4'd14, 4'd5, 16'h0003, 16'h00F4, 16'h0030, 1'b0);
    issue(4'd15, 4'd7, 16'h0001, 16'h8000, 16'h0000, 1'b0);
    issue(4'd0, 4'd8, 16'hFFFF, 16'hFFFF, 16'h0001, 1'b0);
    issue(4'd1, 4'hF, 16'h0000, 16'h0000, 16'h0000, 1'b1);
    idle(4);

    // Same ROB index reused after a flush
    issue(4'd7, 4'd0, 16'h0010, 16'h0001, 16'h0011, 1'b0);
    step(1'b0, 4'd0, 4'd0, 16'h0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b0);
    issue(4'd7, 4'd1, 16'h0010, 16'h0001, 16'h000F, 1'b0);
    issue(4'd7, 4'd2, 16'h00F0, 16'h0030, 16'h0030, 1'b0);
    idle(4);

    // Random stream with sporadic flush and reset
    for (int i = 0; i < 400; i++) begin
      v   = ($urandom_range(0, 3) != 0);
      op  = 4'($urandom_range(0, 15));
      idx = 4'($urandom_range(0, 15));
      a   = 16'($urandom);
      b   = 16'($urandom);
      fl  = ($urandom_range(0, 19) == 0);
      r   = ($urandom_range(0, 59) == 0);
      rr  = ref_alu(op, a, b);
      step(v, idx, op, a, b, fl, r, rr[15:0], rr[16]);
    end
    idle(5);
    check("scoreboard_drained", 32'(q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
